minterm_lut: RTL and testbench
==============================

MINTERM_LUT -- requirements
Module: minterm_lut

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning the number of function inputs (1..8).
REQ-002 The block SHALL have parameter INIT_TABLE, default 16'hC2CA, meaning the reset truth table, where bit i = F(i); width 2**N_IN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input word is valid.
REQ-006 The block SHALL have port in_w, input, N_IN bits: the minterm index to evaluate.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_w this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_f is valid.
REQ-009 The block SHALL have port out_f, output, 1 bit: the function value F(in_w).
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_f.
REQ-011 The block SHALL have port cfg_shift_en, input, 1 bit: shift cfg_din into the shadow table.
REQ-012 The block SHALL have port cfg_din, input, 1 bit: serial truth-table bit, MSB (bit 2**N_IN-1) first.
REQ-013 The block SHALL have port cfg_done, output, 1 bit: one-cycle pulse when the new table becomes active.

Function
REQ-014 The block SHALL define M = 2**N_IN; the active table and the shadow table SHALL each be M bits.
REQ-015 The evaluation pipeline SHALL be 2 stages: S1 registers the one-hot decode of in_w; S2 registers out_f = OR(onehot & active_table).
REQ-016 The block SHALL use a pipeline enable en = !out_valid || out_ready; S1 and S2 SHALL advance only when en=1.
REQ-017 A transfer SHALL occur when in_valid && in_ready; out_valid SHALL rise exactly 2 cycles after an accepted transfer when there is no stall; throughput SHALL be 1 per cycle.
REQ-018 The block SHALL hold out_f and out_valid stable while out_valid && !out_ready.
REQ-019 The FSM SHALL have states IDLE, LOAD and COMMIT_WAIT; in_ready = en && state==IDLE.
REQ-020 In IDLE, cfg_shift_en=1 SHALL shift the first bit, clear the bit counter to 1 and go to LOAD.
REQ-021 In LOAD, each cfg_shift_en=1 SHALL shift one bit (shadow <= {shadow[M-2:0], cfg_din}) and increment the counter; cycles with cfg_shift_en=0 SHALL hold state.
REQ-022 When the M-th bit is shifted, the FSM SHALL go to COMMIT_WAIT; with M=... the transition SHALL occur on the bit that makes count==M.
REQ-023 In COMMIT_WAIT, cfg_shift_en SHALL be ignored; once both S1 and S2 hold no valid entry, active_table <= shadow, cfg_done pulses for 1 cycle, and the FSM returns to IDLE.
REQ-024 Words accepted before LOAD SHALL be evaluated with the old table; words accepted after cfg_done SHALL be evaluated with the new table.
REQ-025 N_IN=1 (M=2) SHALL be supported; the counter width SHALL be N_IN+1 bits, with no wrap before M.

Reset
REQ-026 On rst_n=0, regardless of clk: active_table=INIT_TABLE, shadow=0, counter=0, state=IDLE, S1/S2 valid=0, out_valid=0, out_f=0, cfg_done=0.
REQ-027 A reset during LOAD or COMMIT_WAIT SHALL discard the partial shadow; in-flight words SHALL be dropped.

Configuration
REQ-028 With MINTERM_LUT_READBACK_EN defined, the block SHALL have output cfg_rdata [M-1:0] equal to active_table (reset value INIT_TABLE); without it, the port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-029 Package minterm_lut_pkg SHALL hold the FSM state enum and the default INIT_TABLE constant.
REQ-030 Sub-module dec_n_to_onehot (parameter N_IN, combinational, index -> M-bit one-hot, bit i set for index i) SHALL be instantiated in S1.

Verification
REQ-031 Reset, then drive in_w=0..15 back-to-back with out_ready=1 -> out_f sequence 0,1,0,1,0,0,1,1,0,1,0,0,0,0,1,1, the first out_valid 2 cycles after the first accept.
REQ-032 Hold out_ready=0 for 5 cycles with in_w=3 in S2 -> out_f=1 and out_valid=1 held stable, in_ready=0 while both stages are full, no data lost.
REQ-033 Shift 16 bits of 16'h0001 with gaps, while in_w=0 is in flight -> in_flight result=0 (old table), cfg_done after the pipeline drains, then in_w=0 -> 1 and in_w=1 -> 0.
REQ-034 Assert rst_n=0 after 7 shifted bits, then evaluate in_w=9 -> out_f=1 (INIT_TABLE restored), state=IDLE.
REQ-035 N_IN=1, INIT_TABLE=2'b10: in_w=1 -> 1, in_w=0 -> 0; shift 2 bits of 2'b01 -> cfg_done, then in_w=0 -> 1.
REQ-036 With MINTERM_LUT_READBACK_EN defined: cfg_rdata=16'hC2CA after reset and 16'h0001 the cycle after cfg_done.

Source files
------------

// File: rtl/minterm_lut_pkg.sv
// Shared types and constants for the minterm lookup table.
package minterm_lut_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_LOAD        = 2'd1,
      ST_COMMIT_WAIT = 2'd2
   } state_e;

   localparam logic [15:0] DEFAULT_INIT_TABLE = 16'hC2CA;

endpackage

// File: rtl/dec_n_to_onehot.sv
// Combinational index to one-hot decoder: bit i of the result is set for index i.
module dec_n_to_onehot #(
   parameter int N_IN = 4
) (
   input  logic [N_IN-1:0]    idx_i,
   output logic [2**N_IN-1:0] onehot_o
);

   always_comb begin
      onehot_o        = '0;
      onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/minterm_lut.sv
// Minterm lookup table: 2-stage evaluation pipeline plus serial truth-table reload.
// Define MINTERM_LUT_READBACK_EN to add the cfg_rdata view of the active table.
module minterm_lut
   import minterm_lut_pkg::*;
#(
   parameter int                 N_IN       = 4,
   parameter logic [2**N_IN-1:0] INIT_TABLE = DEFAULT_INIT_TABLE
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [N_IN-1:0]    in_w,
   output logic               in_ready,
   output logic               out_valid,
   output logic               out_f,
   input  logic               out_ready,
   input  logic               cfg_shift_en,
   input  logic               cfg_din,
   output logic               cfg_done,
`ifdef MINTERM_LUT_READBACK_EN
   output logic [2**N_IN-1:0] cfg_rdata,
`endif
   output state_e             dbg_state_o
);

   localparam int              M        = 2**N_IN;
   localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);
   localparam logic [N_IN:0]   CNT_LAST = (N_IN+1)'(M);

   state_e          state_q;
   logic [N_IN:0]   cnt_q, cnt_d;
   logic [M-1:0]    shadow_q, shadow_d;
   logic [M-1:0]    active_q;
   logic            cfg_done_q;

   logic            s1_valid_q;
   logic [M-1:0]    s1_onehot_q;
   logic            out_valid_q;
   logic            out_f_q;

   logic            en;
   logic            accept;
   logic [M-1:0]    dec_onehot;

   // Valid/ready: a word moves on a clock edge where valid && ready; the producer
   // keeps it stable until then and the output holds while out_valid && !out_ready.
   assign en       = !out_valid_q || out_ready;
   assign in_ready = en && (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;

   assign shadow_d = {shadow_q[M-2:0], cfg_din};
   assign cnt_d    = cnt_q + CNT_ONE;

   dec_n_to_onehot #(.N_IN(N_IN)) u_dec (
      .idx_i    (in_w),
      .onehot_o (dec_onehot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_onehot_q <= '0;
         out_valid_q <= 1'b0;
         out_f_q     <= 1'b0;
      end else if (en) begin
         s1_valid_q  <= accept;
         s1_onehot_q <= dec_onehot;
         out_valid_q <= s1_valid_q;
         out_f_q     <= s1_valid_q && (|(s1_onehot_q & active_q));
      end
   end

   // The table swap waits for an empty pipeline so no word straddles two tables.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shadow_q   <= '0;
         active_q   <= INIT_TABLE;
         cfg_done_q <= 1'b0;
      end else begin
         cfg_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cfg_shift_en) begin
                  shadow_q <= shadow_d;
                  cnt_q    <= CNT_ONE;
                  state_q  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (cfg_shift_en) begin
                  shadow_q <= shadow_d;
                  cnt_q    <= cnt_d;
                  if (cnt_d == CNT_LAST) begin
                     state_q <= ST_COMMIT_WAIT;
                  end
               end
            end
            ST_COMMIT_WAIT: begin
               if (!s1_valid_q && !out_valid_q) begin
                  active_q   <= shadow_q;
                  cfg_done_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_valid   = out_valid_q;
   assign out_f       = out_f_q;
   assign cfg_done    = cfg_done_q;
   assign dbg_state_o = state_q;

`ifdef MINTERM_LUT_READBACK_EN
   assign cfg_rdata = active_q;
`endif

endmodule

// File: tb/tb_minterm_lut.sv
// Scoreboard bench for minterm_lut: a 4-input instance and a 1-input instance.
// Build with MINTERM_LUT_READBACK_EN defined to also cover cfg_rdata.
module tb_minterm_lut;
   import minterm_lut_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 4-input instance
   logic       in_valid     = 1'b0;
   logic [3:0] in_w         = '0;
   logic       in_ready;
   logic       out_valid;
   logic       out_f;
   logic       out_ready    = 1'b1;
   logic       cfg_shift_en = 1'b0;
   logic       cfg_din      = 1'b0;
   logic       cfg_done;
   state_e     dbg_state;
`ifdef MINTERM_LUT_READBACK_EN
   logic [15:0] cfg_rdata;
`endif

   // 1-input instance
   logic       in_valid1     = 1'b0;
   logic [0:0] in_w1         = '0;
   logic       in_ready1;
   logic       out_valid1;
   logic       out_f1;
   logic       out_ready1    = 1'b1;
   logic       cfg_shift_en1 = 1'b0;
   logic       cfg_din1      = 1'b0;
   logic       cfg_done1;
   state_e     dbg_state1;
`ifdef MINTERM_LUT_READBACK_EN
   logic [1:0] cfg_rdata1;
`endif

   minterm_lut u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_w         (in_w),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_f        (out_f),
      .out_ready    (out_ready),
      .cfg_shift_en (cfg_shift_en),
      .cfg_din      (cfg_din),
      .cfg_done     (cfg_done),
`ifdef MINTERM_LUT_READBACK_EN
      .cfg_rdata    (cfg_rdata),
`endif
      .dbg_state_o  (dbg_state)
   );

   minterm_lut #(.N_IN(1), .INIT_TABLE(2'b10)) u_dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid1),
      .in_w         (in_w1),
      .in_ready     (in_ready1),
      .out_valid    (out_valid1),
      .out_f        (out_f1),
      .out_ready    (out_ready1),
      .cfg_shift_en (cfg_shift_en1),
      .cfg_din      (cfg_din1),
      .cfg_done     (cfg_done1),
`ifdef MINTERM_LUT_READBACK_EN
      .cfg_rdata    (cfg_rdata1),
`endif
      .dbg_state_o  (dbg_state1)
   );

   int checks   = 0;
   int failures = 0;

   // Truth tables the bench believes are active, one per instance.
   logic [15:0] model_tbl  = 16'hC2CA;
   logic [1:0]  model_tbl1 = 2'b10;
   logic [15:0] new_tbl    = 16'h0001;

   logic [0:0] exp_q[$];
   logic [0:0] exp1_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called and returns one time unit after a rising edge.
   task automatic send(input bit sel, input logic [3:0] w);
      int budget = 40;
      if (sel) begin
         in_valid1 = 1'b1;
         in_w1     = w[0];
      end else begin
         in_valid = 1'b1;
         in_w     = w;
      end
      #1;
      while (!(sel ? in_ready1 : in_ready) && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      if (sel ? in_ready1 : in_ready) begin
         if (sel) exp1_q.push_back(model_tbl1[w[0]]);
         else     exp_q.push_back(model_tbl[w]);
         @(posedge clk);
         #1;
      end else begin
         check("send_timeout", 32'd0, 32'd1);
      end
      in_valid  = 1'b0;
      in_valid1 = 1'b0;
   endtask

   task automatic shift_bit(input bit sel, input logic b, input int gap);
      if (sel) begin
         cfg_shift_en1 = 1'b1;
         cfg_din1      = b;
      end else begin
         cfg_shift_en = 1'b1;
         cfg_din      = b;
      end
      tick(1);
      cfg_shift_en  = 1'b0;
      cfg_shift_en1 = 1'b0;
      tick(gap);
   endtask

   task automatic wait_done(input bit sel);
      int budget = 20;
      while (!(sel ? cfg_done1 : cfg_done) && budget > 0) begin
         tick(1);
         budget--;
      end
      check("cfg_done_pulse", 32'(sel ? cfg_done1 : cfg_done), 32'd1);
      tick(1);
      check("cfg_done_width", 32'(sel ? cfg_done1 : cfg_done), 32'd0);
      check("state_after_commit", 32'(sel ? dbg_state1 : dbg_state), 32'(ST_IDLE));
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
         else check("out_f", 32'(out_f), 32'(exp_q.pop_front()));
      end
      if (rst_n && out_valid1 && out_ready1) begin
         if (exp1_q.size() == 0) check("unexpected_out1", 32'd1, 32'd0);
         else check("out_f1", 32'(out_f1), 32'(exp1_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset values
      tick(1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_f", 32'(out_f), 32'd0);
      check("rst_cfg_done", 32'(cfg_done), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("rst_out_valid1", 32'(out_valid1), 32'd0);
`ifdef MINTERM_LUT_READBACK_EN
      check("rst_rdata", 32'(cfg_rdata), 32'h0000C2CA);
`endif
      tick(1);
      rst_n = 1'b1;
      tick(1);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // first-result latency
      send(0, 4'd0);
      check("lat_cycle1", 32'(out_valid), 32'd0);
      tick(1);
      check("lat_cycle2", 32'(out_valid), 32'd1);
      tick(2);

      // back-to-back stream of every minterm
      for (int i = 0; i < 16; i++) send(0, 4'(i));
      tick(4);
      check("stream_drained", 32'(exp_q.size()), 32'd0);

      // downstream stall with in_w=3 in S2 and in_w=4 behind it
      out_ready = 1'b0;
      send(0, 4'd3);
      send(0, 4'd4);
      for (int i = 0; i < 5; i++) begin
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_f", 32'(out_f), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         tick(1);
      end
      out_ready = 1'b1;
      tick(4);
      check("stall_no_loss", 32'(exp_q.size()), 32'd0);

      // reload 16'h0001 with an old-table word parked in the pipeline
      out_ready = 1'b0;
      send(0, 4'd0);
      for (int i = 15; i >= 0; i--) shift_bit(0, new_tbl[i], (i % 3 == 0) ? 1 : 0);
      check("load_to_commit", 32'(dbg_state), 32'(ST_COMMIT_WAIT));
      shift_bit(0, 1'b1, 1);
      check("commit_waits_drain", 32'(cfg_done), 32'd0);
      check("commit_state_hold", 32'(dbg_state), 32'(ST_COMMIT_WAIT));
      out_ready = 1'b1;
      wait_done(0);
      model_tbl = new_tbl;
`ifdef MINTERM_LUT_READBACK_EN
      check("rdata_new", 32'(cfg_rdata), 32'h00000001);
`endif
      send(0, 4'd0);
      send(0, 4'd1);
      tick(4);
      check("reload_drained", 32'(exp_q.size()), 32'd0);

      // reset in the middle of a load drops the partial table and in-flight words
      out_ready = 1'b0;
      send(0, 4'd5);
      for (int i = 0; i < 7; i++) shift_bit(0, 1'b1, 0);
      check("mid_load_state", 32'(dbg_state), 32'(ST_LOAD));
      rst_n = 1'b0;
      #1;
      check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      exp_q.delete();
      exp1_q.delete();
      out_ready = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      model_tbl = 16'hC2CA;
      check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef MINTERM_LUT_READBACK_EN
      check("post_rst_rdata", 32'(cfg_rdata), 32'h0000C2CA);
`endif
      send(0, 4'd9);
      send(0, 4'd2);
      tick(4);
      check("post_rst_drained", 32'(exp_q.size()), 32'd0);

      // single-input instance: initial table, then reload with 2'b01
      send(1, 4'd1);
      send(1, 4'd0);
      tick(3);
      shift_bit(1, 1'b0, 0);
      shift_bit(1, 1'b1, 1);
      wait_done(1);
      model_tbl1 = 2'b01;
`ifdef MINTERM_LUT_READBACK_EN
      check("rdata1_new", 32'(cfg_rdata1), 32'd1);
`endif
      send(1, 4'd0);
      send(1, 4'd1);
      tick(4);
      check("n1_drained", 32'(exp1_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
